// File: rtl/instr_loader.sv
// Instruction loader: packs a big-endian serial byte stream into 32-bit words and writes them
// to instruction memory while holding the CPU. Define CHECKSUM_EN for a trailing checksum byte.
module instr_loader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  num_words,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        chk_err
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRecv  = 3'd1,
    StWrite = 3'd2,
`ifdef CHECKSUM_EN
    StCheck = 3'd3,
`endif
    StDone  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  word_cnt_q, word_cnt_d;
  logic [7:0]  num_words_q, num_words_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic byte_acc;
  logic start_acc;
  logic last_word;

  assign byte_acc  = byte_valid & byte_ready;
  // start is only honoured when not busy
  assign start_acc = start & ((state_q == StIdle) | (state_q == StDone));
  assign last_word = (word_cnt_q + 8'd1) == num_words_q;

  // ---------------------------------------------------------------------------------------------
  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = (num_words == 8'd0) ? StDone : StRecv;
        end
      end
      StRecv: begin
        if (byte_acc && (byte_idx_q == 2'd3)) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (!last_word) begin
          state_d = StRecv;
        end else begin
`ifdef CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef CHECKSUM_EN
      StCheck: begin
        if (byte_acc) begin
          state_d = StDone;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      StRecv: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      StWrite: begin
        mem_we = 1'b1;
        busy   = 1'b1;
      end
`ifdef CHECKSUM_EN
      StCheck: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
`endif
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  assign cpu_hold  = busy;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // ---------------------------------------------------------------------------------------------
  // Datapath
  always_comb begin
    byte_idx_d  = byte_idx_q;
    word_cnt_d  = word_cnt_q;
    num_words_d = num_words_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if (start_acc) begin
      byte_idx_d  = 2'd0;
      word_cnt_d  = 8'd0;
      num_words_d = num_words;
      addr_d      = 32'd0;
      wdata_d     = 32'd0;
    end else if (state_q == StRecv) begin
      if (byte_acc) begin
        // shifting left makes the first byte land in [31:24]
        wdata_d    = {wdata_q[23:0], byte_data};
        byte_idx_d = byte_idx_q + 2'd1;
      end
    end else if (state_q == StWrite) begin
      word_cnt_d = word_cnt_q + 8'd1;
      addr_d     = addr_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx_q  <= 2'd0;
      word_cnt_q  <= 8'd0;
      num_words_q <= 8'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
    end else begin
      byte_idx_q  <= byte_idx_d;
      word_cnt_q  <= word_cnt_d;
      num_words_q <= num_words_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Optional modulo-256 checksum over program bytes, compared against one trailing byte
`ifdef CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       chk_err_q, chk_err_d;

  always_comb begin
    sum_d     = sum_q;
    chk_err_d = chk_err_q;
    if (start_acc) begin
      sum_d     = 8'd0;
      chk_err_d = 1'b0;
    end else if ((state_q == StRecv) && byte_acc) begin
      sum_d = sum_q + byte_data;
    end else if ((state_q == StCheck) && byte_acc) begin
      chk_err_d = (byte_data != sum_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= 8'd0;
      chk_err_q <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      chk_err_q <= chk_err_d;
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed scenarios plus randomized loads checked
// against a word-list model built from the byte stream.
`timescale 1ns/1ps
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  num_words = 8'd0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        chk_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  stim_q[$];
  logic [63:0] got_q[$];

  always #5 clk = ~clk;

  instr_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_words  (num_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .chk_err    (chk_err)
  );

  // Record every memory write seen mid-cycle
  always @(negedge clk) begin
    if (rst_n && mem_we === 1'b1) got_q.push_back({mem_addr, mem_wdata});
  end

  function automatic logic [7:0] model_sum();
    logic [7:0] s = 8'd0;
    foreach (stim_q[i]) s += stim_q[i];
    return s;
  endfunction

  task automatic fill_random(input int nbytes);
    stim_q.delete();
    for (int i = 0; i < nbytes; i++) stim_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Called at a falling edge; returns at the falling edge after the byte is accepted
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) begin
        @(negedge clk);
        n_checks++;
        if (cpu_hold !== 1'b1 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL hold_in_gap: cpu_hold=%b busy=%b required 1/1", cpu_hold, busy);
        end
      end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (byte_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL byte_accept_timeout: byte_ready=%b required 1 within 20 cycles", byte_ready);
      byte_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_start(input logic [7:0] n);
    byte_valid = 1'b0;
    start      = 1'b1;
    num_words  = n;
    @(negedge clk);
    start     = 1'b0;
    num_words = 8'($urandom_range(0, 255));  // must be ignored after sampling
  endtask

  // Loads stim_q (4*n bytes); optionally pulses start (num_words=5) before byte inj_at
  task automatic load_and_check(input string name, input int n, input int gap, input bit rnd_gap,
                                input int inj_at, input logic [7:0] trailing);
    logic [31:0] w;
    logic [63:0] exp_e;
    logic [7:0]  sum;
    logic        exp_err;
    bit          ok;
    got_q.delete();
    do_start(8'(n));
    n_checks++;
    if (done !== 1'b0 || chk_err !== 1'b0 || busy !== 1'b1 || cpu_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_start: done=%b chk_err=%b busy=%b hold=%b required 0/0/1/1", name, done,
               chk_err, busy, cpu_hold);
    end
    sum = model_sum();
    for (int i = 0; i < stim_q.size(); i++) begin
      if (i == inj_at) begin
        byte_valid = 1'b0;
        start      = 1'b1;
        num_words  = 8'd5;
        @(negedge clk);
        start = 1'b0;
      end
      send_byte(stim_q[i], rnd_gap ? int'($urandom_range(0, gap)) : gap);
      if (i % 4 == 3) begin
        w = {stim_q[i-3], stim_q[i-2], stim_q[i-1], stim_q[i]};
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'(4 * (i / 4)) || mem_wdata !== w) begin
          n_fail++;
          $display("FAIL %s_write_timing: we=%b addr=%h data=%h required 1/%h/%h", name, mem_we,
                   mem_addr, mem_wdata, 32'(4 * (i / 4)), w);
        end
      end
    end
`ifdef CHECKSUM_EN
    send_byte(trailing, 0);
    exp_err = (trailing != sum);
`else
    exp_err = 1'b0;
`endif
    byte_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_done_timeout: done=%b required 1", name, done);
    end
    n_checks++;
    if (busy !== 1'b0 || cpu_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_after: busy=%b hold=%b required 0/0", name, busy, cpu_hold);
    end
    n_checks++;
    if (got_q.size() != n) begin
      n_fail++;
      $display("FAIL %s_write_count: got %0d writes required %0d", name, got_q.size(), n);
    end
    for (int k = 0; k < n && k < got_q.size(); k++) begin
      exp_e = {32'(4 * k), stim_q[4*k], stim_q[4*k+1], stim_q[4*k+2], stim_q[4*k+3]};
      n_checks++;
      if (got_q[k] !== exp_e) begin
        n_fail++;
        $display("FAIL %s_write%0d: addr/data=%h required %h", name, k, got_q[k], exp_e);
      end
    end
    n_checks++;
    if (chk_err !== exp_err) begin
      n_fail++;
      $display("FAIL %s_chk_err: chk_err=%b required %b (sum %h)", name, chk_err, exp_err, sum);
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, chk_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b we=%b addr=%h data=%h hold=%b busy=%b done=%b err=%b required all 0",
               byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, chk_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || byte_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b done=%b rdy=%b required 0/0/0", busy, done, byte_ready);
    end
  endtask

  task automatic test_back_to_back();
    stim_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    load_and_check("b2b", 2, 0, 1'b0, -1, model_sum());
  endtask

  task automatic test_gaps();
    stim_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    load_and_check("gaps", 1, 3, 1'b0, -1, model_sum());
  endtask

  task automatic test_zero_words();
    int rdy_seen = 0;
    got_q.delete();
    do_start(8'd0);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done: done=%b busy=%b required 1/0", done, busy);
    end
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    repeat (5) begin
      if (byte_ready !== 1'b0) rdy_seen++;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    n_checks++;
    if (rdy_seen != 0 || got_q.size() != 0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_no_traffic: ready cycles=%0d writes=%0d done=%b required 0/0/1", rdy_seen,
               got_q.size(), done);
    end
  endtask

  task automatic test_reset_midload();
    fill_random(12);
    do_start(8'd3);
    for (int i = 0; i < 6; i++) send_byte(stim_q[i], 0);
    byte_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, chk_err} !== '0) begin
      n_fail++;
      $display("FAIL midload_reset: rdy=%b we=%b addr=%h data=%h hold=%b busy=%b done=%b err=%b required all 0",
               byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, chk_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    repeat (6) @(negedge clk);
    byte_valid = 1'b0;
    n_checks++;
    if (got_q.size() != 0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL midload_quiet: writes=%0d busy=%b done=%b required 0/0/0", got_q.size(), busy,
               done);
    end
    fill_random(4);
    load_and_check("after_reset", 1, 0, 1'b0, -1, model_sum());
  endtask

  task automatic test_start_ignored();
    fill_random(8);
    load_and_check("start_ignored", 2, 1, 1'b1, 3, model_sum());
  endtask

  task automatic test_checksum();
`ifdef CHECKSUM_EN
    stim_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    load_and_check("chk_good", 1, 0, 1'b0, -1, 8'h0A);
    load_and_check("chk_bad", 1, 0, 1'b0, -1, 8'h0B);
`else
    stim_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    load_and_check("nochk", 1, 0, 1'b0, -1, 8'h0B);
`endif
  endtask

  task automatic test_random();
    int n;
    logic [7:0] t;
    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(1, 6));
      fill_random(4 * n);
      t = model_sum();
      if ($urandom_range(0, 1) == 1) t = t ^ 8'($urandom_range(1, 255));
      load_and_check($sformatf("rand%0d", r), n, 2, 1'b1, -1, t);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_zero_words();
    test_reset_midload();
    test_start_ignored();
    test_checksum();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
